ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: the send side of the existing keyboard receive path.
- Takes one command byte from the CPU-side GPIO logic, for example `0xED` (set LEDs) or `0xF4` (enable).
- Runs the PS/2 request-to-send sequence and shifts the byte out LSB-first with odd parity and stop bit.
- Checks the device acknowledge bit.
- Runs in the 25 MHz domain beside the keyboard receiver and drives the open-drain PS/2 clock and data pads.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_line_sync.sv | 63 ++++++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame geometry
// and the odd-parity helper used to build the outgoing frame.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 10;  // 8 data + parity + stop
   localparam int PS2_ACK_EDGE   = 11;  // device clock edge carrying the acknowledge

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   // Frame bit i is driven after device clock falling edge i+1.
   function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] data);
      return {1'b1, odd_parity(data), data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the CPU-side GPIO logic (master) and the PS/2
// host transmitter (slave).
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_done, tx_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_done, tx_err
   );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning: 2-flop synchronisers on clock and data, falling-edge
// pulse on the clock. Define PS2_TX_FILTER_EN to add a 4-sample clock glitch filter.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2c_i,
   input  logic ps2d_i,
   output logic clk_level,
   output logic clk_fall,
   output logic data_level
);

   logic [1:0] c_sync;
   logic [1:0] d_sync;
   logic       c_level;
   logic       c_level_q;

   // NOTE: synchroniser flops reset to 1, the idle bus level, so leaving
   // reset never looks like a device clock falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_sync <= 2'b11;
         d_sync <= 2'b11;
      end else begin
         c_sync <= {c_sync[0], ps2c_i};
         d_sync <= {d_sync[0], ps2d_i};
      end
   end

`ifdef PS2_TX_FILTER_EN
   logic       c_filt;
   logic [1:0] filt_cnt;

   // A new clock level is taken only after 4 consecutive samples agree on it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_filt   <= 1'b1;
         filt_cnt <= 2'd0;
      end else if (c_sync[1] == c_filt) begin
         filt_cnt <= 2'd0;
      end else if (filt_cnt == 2'd3) begin
         c_filt   <= c_sync[1];
         filt_cnt <= 2'd0;
      end else begin
         filt_cnt <= filt_cnt + 2'd1;
      end
   end

   assign c_level = c_filt;
`else
   assign c_level = c_sync[1];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) c_level_q <= 1'b1;
      else      c_level_q <= c_level;
   end

   assign clk_level  = c_level;
   assign clk_fall   = c_level_q & ~c_level;
   assign data_level = d_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, LSB-first shift with odd
// parity and stop, acknowledge check. PS2_TX_FILTER_EN enables the clock glitch filter.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 3000,
   parameter int HOLD_CYC    = 25,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  tx,
   output logic          rx_inhibit,
   input  logic          ps2c_i,
   input  logic          ps2d_i,
   output logic          ps2c_oe,
   output logic          ps2d_oe
);

   localparam int CNT_MAX0 = (INHIBIT_CYC > HOLD_CYC) ? INHIBIT_CYC : HOLD_CYC;
   localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int BIT_W    = $clog2(PS2_ACK_EDGE + 1);

   ps2_state_e                state;
   logic [PS2_FRAME_BITS-1:0] frame;
   logic [BIT_W-1:0]          bit_cnt;
   logic [CNT_W-1:0]          cyc_cnt;
   logic                      clk_level;
   logic                      clk_fall;
   logic                      data_level;
   logic                      timeout_hit;

   ps2_line_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .ps2c_i     (ps2c_i),
      .ps2d_i     (ps2d_i),
      .clk_level  (clk_level),
      .clk_fall   (clk_fall),
      .data_level (data_level)
   );

   assign timeout_hit = (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // NOTE: every output is assigned here with <= alongside the state, so the
   // pads and pulses come straight from flops and cannot glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         frame       <= '0;
         bit_cnt     <= '0;
         cyc_cnt     <= '0;
         ps2c_oe     <= 1'b0;
         ps2d_oe     <= 1'b0;
         rx_inhibit  <= 1'b0;
         tx.tx_ready <= 1'b1;
         tx.tx_done  <= 1'b0;
         tx.tx_err   <= 1'b0;
      end else begin
         tx.tx_done <= 1'b0;
         tx.tx_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx.tx_valid) begin
                  frame       <= build_frame(tx.tx_data);
                  bit_cnt     <= '0;
                  cyc_cnt     <= '0;
                  ps2c_oe     <= 1'b1;
                  rx_inhibit  <= 1'b1;
                  tx.tx_ready <= 1'b0;
                  state       <= ST_INHIBIT;
               end
            end

            ST_INHIBIT: begin
               if (cyc_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                  cyc_cnt <= '0;
                  ps2d_oe <= 1'b1;
                  state   <= ST_REQ;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_REQ: begin
               if (cyc_cnt == CNT_W'(HOLD_CYC - 1)) begin
                  cyc_cnt <= '0;
                  ps2c_oe <= 1'b0;
                  state   <= ST_SHIFT;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            // A device edge always beats a simultaneous timeout.
            ST_SHIFT: begin
               if (clk_fall) begin
                  ps2d_oe <= ~frame[bit_cnt];
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  cyc_cnt <= '0;
                  if (bit_cnt == BIT_W'(PS2_FRAME_BITS - 1)) state <= ST_ACK;
               end else if (timeout_hit) begin
                  ps2c_oe     <= 1'b0;
                  ps2d_oe     <= 1'b0;
                  rx_inhibit  <= 1'b0;
                  tx.tx_ready <= 1'b1;
                  tx.tx_err   <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_ACK: begin
               if (clk_fall) begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  cyc_cnt <= '0;
                  if (!data_level) begin
                     state <= ST_WAIT_IDLE;
                  end else begin
                     rx_inhibit  <= 1'b0;
                     tx.tx_ready <= 1'b1;
                     tx.tx_err   <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end else if (timeout_hit) begin
                  ps2c_oe     <= 1'b0;
                  ps2d_oe     <= 1'b0;
                  rx_inhibit  <= 1'b0;
                  tx.tx_ready <= 1'b1;
                  tx.tx_err   <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            ST_WAIT_IDLE: begin
               if (clk_fall) begin
                  cyc_cnt <= '0;
               end else if (clk_level && data_level) begin
                  rx_inhibit  <= 1'b0;
                  tx.tx_ready <= 1'b1;
                  tx.tx_done  <= 1'b1;
                  state       <= ST_IDLE;
               end else if (timeout_hit) begin
                  ps2c_oe     <= 1'b0;
                  ps2d_oe     <= 1'b0;
                  rx_inhibit  <= 1'b0;
                  tx.tx_ready <= 1'b1;
                  tx.tx_err   <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain pad model plus a scripted PS/2
// device that clocks frames, samples bits on rising edges and acknowledges.
module tb_ps2_host_tx;

   localparam int INHIBIT = 20;
   localparam int HOLD    = 5;
   localparam int TMO     = 200;
   localparam int HALF    = 10;
`ifdef PS2_TX_FILTER_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_host_tx_if tx_if ();
   logic rx_inhibit, ps2c_oe, ps2d_oe;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   wire  ps2c_pad = ~(ps2c_oe | dev_clk_low);
   wire  ps2d_pad = ~(ps2d_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYC (INHIBIT),
      .HOLD_CYC    (HOLD),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx         (tx_if),
      .rx_inhibit (rx_inhibit),
      .ps2c_i     (ps2c_pad),
      .ps2d_i     (ps2d_pad),
      .ps2c_oe    (ps2c_oe),
      .ps2d_oe    (ps2d_oe)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int done_cnt = 0, err_cnt = 0, err_cyc = 0, pulse_bad = 0;
   logic prev_done = 1'b0, prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts done/err, flags pulses longer than one cycle or
   // pulses that do not coincide with tx_ready high.
   always @(negedge clk) begin
      if (tx_if.tx_done === 1'b1) done_cnt++;
      if (tx_if.tx_err === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if ((tx_if.tx_done === 1'b1 || tx_if.tx_err === 1'b1) && tx_if.tx_ready !== 1'b1) pulse_bad++;
      if ((tx_if.tx_done === 1'b1 && prev_done) || (tx_if.tx_err === 1'b1 && prev_err)) pulse_bad++;
      prev_done = (tx_if.tx_done === 1'b1);
      prev_err  = (tx_if.tx_err === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request a send and follow it to the clock release; optionally pulse a
   // second request (0xAA) while the block is in INHIBIT.
   task automatic start_tx(input logic [7:0] d, input logic inject);
      int n;
      @(negedge clk);
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_if.tx_valid = 1'b0;
      check("accept_c_oe", ps2c_oe, 1);
      check("accept_inhibit", rx_inhibit, 1);
      check("accept_ready", tx_if.tx_ready, 0);
      n = 0;
      while (ps2c_oe === 1'b1 && n < 1000) begin
         if (inject && n == 5) begin
            tx_if.tx_data  = 8'hAA;
            tx_if.tx_valid = 1'b1;
         end
         if (inject && n == 6) begin
            check("inject_ready", tx_if.tx_ready, 0);
            tx_if.tx_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      check("release_cyc", n, INHIBIT + HOLD);
      check("start_bit", ps2d_pad, 0);
   endtask

   // Device: n_edges clock pulses; bits sampled on rising edges 1..10;
   // acknowledge by pulling data low around edge 11.
   task automatic dev_frame(input int n_edges, input logic ack, input logic glitch,
                            output logic [9:0] cap);
      cap = '0;
      repeat (5) @(posedge clk);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack) dev_data_low = 1'b1;
         @(posedge clk);
         #1 dev_clk_low = 1'b1;
         fall_cyc = cyc;
         repeat (HALF) @(posedge clk);
         #1 dev_clk_low = 1'b0;
         if (k <= 10) cap[k-1] = ps2d_pad;
         if (k == 11) dev_data_low = 1'b0;
         if (glitch && k < 10) begin
            repeat (4) @(posedge clk);
            #1 dev_clk_low = 1'b1;
            repeat (2) @(posedge clk);
            #1 dev_clk_low = 1'b0;
            repeat (HALF - 6) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
      end
   endtask

   initial begin
      logic [9:0] cap;
      int d0, e0, n;

      tx_if.tx_data  = 8'h00;
      tx_if.tx_valid = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_c_oe", ps2c_oe, 0);
      check("rst_d_oe", ps2d_oe, 0);
      check("rst_done", tx_if.tx_done, 0);
      check("rst_err", tx_if.tx_err, 0);
      check("rst_inhibit", rx_inhibit, 0);
      check("rst_ready", tx_if.tx_ready, 1);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);

      // 0xED acknowledged: 1,0,1,1,0,1,1,1 then parity 1, stop 1
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hED, 1'b0);
      dev_frame(11, 1'b1, 1'b0, cap);
      repeat (5) @(posedge clk);
      #1;
      check("ed_bits", cap, 10'h3ED);
      check("ed_done", done_cnt - d0, 1);
      check("ed_err", err_cnt - e0, 0);
      check("ed_ready", tx_if.tx_ready, 1);
      check("ed_inhibit", rx_inhibit, 0);

      // 0xF4 without acknowledge: parity 0, error on edge 11
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hF4, 1'b0);
      dev_frame(11, 1'b0, 1'b0, cap);
      repeat (5) @(posedge clk);
      #1;
      check("f4_bits", cap, 10'h2F4);
      check("f4_err", err_cnt - e0, 1);
      check("f4_err_lat", err_cyc - fall_cyc, LAT);
      check("f4_done", done_cnt - d0, 0);
      check("f4_ready", tx_if.tx_ready, 1);
      check("f4_d_oe", ps2d_oe, 0);

      // 0x00, device stops after edge 4: timeout error
      e0 = err_cnt;
      start_tx(8'h00, 1'b0);
      dev_frame(4, 1'b0, 1'b0, cap);
      check("tmo_d_held", ps2d_oe, 1);
      n = 0;
      while (err_cnt == e0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("tmo_err", err_cnt - e0, 1);
      check("tmo_lat", err_cyc - fall_cyc, LAT + TMO);
      check("tmo_c_oe", ps2c_oe, 0);
      check("tmo_d_oe", ps2d_oe, 0);
      check("tmo_ready", tx_if.tx_ready, 1);

      // 0xED with reset mid-shift (bit 1 = 0 drives data low), then 0xF4
      start_tx(8'hED, 1'b0);
      dev_frame(2, 1'b0, 1'b0, cap);
      check("mid_d_oe", ps2d_oe, 1);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_d_oe", ps2d_oe, 0);
      check("mid_rst_c_oe", ps2c_oe, 0);
      check("mid_rst_inhibit", rx_inhibit, 0);
      check("mid_rst_ready", tx_if.tx_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hF4, 1'b0);
      dev_frame(11, 1'b1, 1'b0, cap);
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_bits", cap, 10'h2F4);
      check("post_rst_done", done_cnt - d0, 1);
      check("post_rst_err", err_cnt - e0, 0);

      // 0x55 with a 0xAA request during INHIBIT: ignored
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'h55, 1'b1);
      dev_frame(11, 1'b1, 1'b0, cap);
      repeat (20) @(posedge clk);
      #1;
      check("x55_bits", cap, 10'h355);
      check("x55_done", done_cnt - d0, 1);
      check("x55_err", err_cnt - e0, 0);

`ifdef PS2_TX_FILTER_EN
      // 2-cycle clock glitches during SHIFT must not advance the bit counter
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hED, 1'b0);
      dev_frame(11, 1'b1, 1'b1, cap);
      repeat (5) @(posedge clk);
      #1;
      check("glitch_bits", cap, 10'h3ED);
      check("glitch_done", done_cnt - d0, 1);
      check("glitch_err", err_cnt - e0, 0);
`endif

      check("pulse_shape", pulse_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
